mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the core's instruction-fetch port and its load/store port.
- Sits between core and memory: i_* connects to the fetch side (port_inst_addr/port_inst_in), d_* to the memacc side (port_data_addr/port_data_out/port_data_in, port_memacc_type/valid), mem_* to the memory.
- Runs one transaction at a time, with data-priority arbitration and a bounded starvation limit for fetch.
- Returns registered read data to the requester with a one-cycle ack pulse.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MEM_LAT, 2, cycles from the mem_valid cycle to the cycle mem_rdata is valid; legal range 1..15.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  global enable; when low, no new transaction is accepted.
- i_req  in  1  fetch request; held with i_addr until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word; valid while i_ack=1, held afterwards.
- i_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load result; valid while d_ack=1; unchanged by stores.
- d_ack  out  1  one-cycle completion pulse for data.
- mem_valid  out  1  one-cycle command strobe to memory.
- mem_we  out  1  write strobe, qualified by mem_valid.
- mem_addr  out  ADDR_W  memory address; held for the whole transaction.
- mem_wdata  out  DATA_W  memory write data; held for the whole transaction.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_valid.
- busy  out  1  1 while a transaction is outstanding (state != IDLE).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, streak=0, latency counter=0.
  - All outputs 0, including i_rdata, d_rdata, mem_addr and mem_wdata.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: on an edge with enable=1 and (i_req or d_req):
  - Latch the winner's addr, we (fetch forces we=0) and wdata into the mem_* registers.
  - Record the owner; go to ISSUE.
  - With enable=0, stay in IDLE and ignore requests.
- Arbitration, when both requests are high:
  - Data wins unless streak==MAX_DATA_STREAK, in which case fetch wins.
  - streak increments on a data grant taken while i_req=1.
  - streak resets to 0 on any fetch grant, or on a data grant taken with i_req=0.
  - A single requester always wins.
- ISSUE (1 cycle): mem_valid=1 and mem_we per the latched op; load the counter with MEM_LAT; go to WAIT.
- WAIT:
  - mem_valid=0; counter decrements each edge.
  - On the edge ending the cycle where mem_rdata is valid (the MEM_LAT-th cycle after ISSUE):
    - for a read, register mem_rdata into the owner's rdata;
    - for a store, leave d_rdata unchanged;
    - assert the owner's ack; go to RESP.
- RESP (1 cycle): owner's ack=1; on the next edge, ack returns to 0 and state returns to IDLE.
- Request-to-ack latency: request sampled at the end of cycle 0, mem_valid in cycle 1, ack in cycle MEM_LAT+2.
  - Example for MEM_LAT=2: mem_valid in cycle 1, ack in cycle 4.
- Back-to-back: a request still high at the edge leaving RESP is not accepted at that edge. It is sampled in IDLE one cycle later, so the minimum period is MEM_LAT+3 cycles per transaction.
- i_ack and d_ack are never high in the same cycle; at most one transaction is outstanding.
- enable=0 during ISSUE, WAIT or RESP: the in-flight transaction still completes and acks (memory cannot be paused); only IDLE acceptance is gated.
- Requester drops req before ack: the transaction still completes, and the ack pulse is still generated and may be ignored.
- Reset asserted mid-transaction: everything returns to the reset values immediately; no ack is produced; returning mem_rdata is ignored.
- Addresses and data pass through unchanged; no alignment checks.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan:
- Reset, then a single fetch i_addr=0x100 with MEM_LAT=2, memory returning 0x00500093 → mem_valid in cycle 1 with mem_addr=0x100, mem_we=0; i_ack=1 and i_rdata=0x00500093 in cycle 4 only; busy=1 in cycles 1-4.
- Store d_addr=0x200, d_wdata=0xDEADBEEF, d_rdata previously 0x12345678 → mem_we=1, mem_wdata=0xDEADBEEF in cycle 1; d_ack in cycle 4; d_rdata stays 0x12345678.
- i_req and d_req held continuously, MAX_DATA_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I; acks 5 cycles apart; never both acks at once.
- enable dropped in the cycle after acceptance → transaction completes with ack in cycle 4; while enable=0, a pending d_req produces no mem_valid; once enable=1, mem_valid follows in the cycle after the next IDLE edge.
- rst pulsed low in WAIT → all outputs 0 immediately; no i_ack/d_ack appears; the next request after release gets the normal MEM_LAT+2 latency.
- MEM_LAT=1, d_req load from 0x40, memory returns 0xCAFEF00D → ack in cycle 3 with d_rdata=0xCAFEF00D; next back-to-back request gets mem_valid 4 cycles after the previous one.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-ported memory between fetch and load/store,
// data-priority with a bounded fetch-starvation streak, one transaction in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LAT         = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic              own_d_q;
    logic [3:0]        streak_q, streak_d, cnt_q;
    logic              data_win;
    logic              mem_valid_q, mem_we_q, i_ack_q, d_ack_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;

    // Fetch is forced only once data has been granted MAX_DATA_STREAK times while it waited.
    always_comb begin
        data_win = d_req && !(i_req && streak_q == 4'(MAX_DATA_STREAK));
        streak_d = (data_win && i_req) ? streak_q + 4'd1 : 4'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            own_d_q     <= 1'b0;
            streak_q    <= '0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (enable && (i_req || d_req)) begin
                    own_d_q     <= data_win;
                    mem_we_q    <= data_win && d_we;
                    mem_addr_q  <= data_win ? d_addr : i_addr;
                    mem_wdata_q <= data_win ? d_wdata : '0;
                    mem_valid_q <= 1'b1;
                    streak_q    <= streak_d;
                    state_q     <= ISSUE;
                end
                ISSUE: begin
                    mem_valid_q <= 1'b0;
                    cnt_q       <= 4'(MEM_LAT);
                    state_q     <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    // cnt_q==1 marks the cycle in which mem_rdata is valid
                    if (cnt_q == 4'd1) begin
                        if (!mem_we_q && own_d_q) d_rdata_q <= mem_rdata;
                        if (!own_d_q) i_rdata_q <= mem_rdata;
                        d_ack_q <= own_d_q;
                        i_ack_q <= !own_d_q;
                        state_q <= RESP;
                    end
                end
                default: begin
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter with MEM_LAT=2 and MEM_LAT=1 instances
// and a behavioural fixed-latency memory that drives garbage outside the valid cycle.
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0, rst = 1'b0, enable = 1'b0;
    always #5 clk = ~clk;

    logic        i_req = 0, d_req = 0, d_we = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_valid, mem_we, busy;

    logic        i_req1 = 0, d_req1 = 0, d_we1 = 0;
    logic [31:0] i_addr1 = 0, d_addr1 = 0, d_wdata1 = 0;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        i_ack1, d_ack1, mem_valid1, mem_we1, busy1;

    mem_arbiter #(.MEM_LAT(LAT), .MAX_DATA_STREAK(4)) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(1), .MAX_DATA_STREAK(4)) u_lat1 (
        .clk(clk), .rst(rst), .enable(enable),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_rdata(d_rdata1), .d_ack(d_ack1),
        .mem_valid(mem_valid1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a == 32'h100 ? 32'h00500093 : a == 32'h300 ? 32'h12345678 :
               a == 32'h204 ? 32'hA5A55A5A : {a[15:0], 16'h600D};
    endfunction

    // Memory for the LAT=2 instance: data only valid LAT cycles after the command.
    logic [31:0] mem [0:255];
    logic [255:0] wr = '0;
    logic [31:0] ra_q = 0, ra1_q = 0;
    int mc = 0, mc1 = 0;
    always @(posedge clk) begin
        if (mem_valid) begin
            ra_q <= mem_addr;
            mc   <= 1;
            if (mem_we) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                wr[mem_addr[9:2]]  <= 1'b1;
            end
        end else mc <= (mc != 0 && mc < LAT) ? mc + 1 : 0;
        ra1_q <= mem_valid1 ? mem_addr1 : ra1_q;
        mc1   <= mem_valid1 ? 1 : 0;
    end
    always_comb begin
        mem_rdata  = (mc == LAT) ? (wr[ra_q[9:2]] ? mem[ra_q[9:2]] : dflt(ra_q)) : 32'hBAD0BAD0;
        mem_rdata1 = (mc1 == 1) ? (ra1_q == 32'h40 ? 32'hCAFEF00D : ra1_q ^ 32'h5A5A0000) : 32'hBAD0BAD0;
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [7];

    task automatic xact(input vec_t v);
        if (v.is_d) begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1; i_addr = v.addr;
        end
        tick();
        chk("issue_valid", mem_valid, 1);
        chk("issue_addr", mem_addr, v.addr);
        chk("issue_we", mem_we, v.we);
        chk("issue_busy", busy, 1);
        if (v.we) chk("issue_wdata", mem_wdata, v.wdata);
        for (int c = 2; c <= LAT + 1; c++) begin
            tick();
            chk("wait_ack", {i_ack, d_ack}, 0);
            chk("wait_valid", mem_valid, 0);
            chk("wait_busy", busy, 1);
        end
        tick();
        chk("resp_ack", {i_ack, d_ack}, v.is_d ? 2'b01 : 2'b10);
        chk("resp_rdata", v.is_d ? d_rdata : i_rdata, v.exp);
        chk("resp_busy", busy, 1);
        i_req = 0; d_req = 0; d_we = 0;
        tick();
        chk("idle_ack", {i_ack, d_ack}, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        string exp_ord;
        int    cyc, last, got;
        byte   g;
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'h00500093};
        vecs[1] = '{1'b1, 1'b0, 32'h300, 32'h0,        32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'h12345678};
        vecs[3] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b0, 32'h204, 32'h0,        32'hA5A55A5A};
        vecs[5] = '{1'b1, 1'b1, 32'h204, 32'h0BADF00D, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 1'b0, 32'h204, 32'h0,        32'h0BADF00D};

        tick(); tick();
        chk("rst_valid", mem_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {i_ack, d_ack}, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_drdata", d_rdata, 0);
        rst = 1; enable = 1;
        tick();

        for (int k = 0; k < 7; k++) xact(vecs[k]);

        // Both requesters held: data gets four grants, then fetch is forced.
        exp_ord = "DDDDIDDDDI";
        i_addr = 32'h100; d_addr = 32'h300; d_we = 0;
        i_req = 1; d_req = 1;
        cyc = 0; last = -1; got = 0;
        while (got < 10 && cyc < 200) begin
            tick();
            cyc++;
            chk("ack_exclusive", i_ack & d_ack, 0);
            if (i_ack | d_ack) begin
                g = d_ack ? 8'h44 : 8'h49;
                chk("grant_order", g, exp_ord[got]);
                if (last >= 0) chk("ack_spacing", cyc - last, LAT + 3);
                last = cyc;
                got++;
            end
        end
        chk("streak_grants", got, 10);
        i_req = 0; d_req = 0;
        tick(); tick();

        // enable dropped after acceptance: in-flight op completes, new ones wait.
        d_req = 1; d_we = 0; d_addr = 32'h200;
        tick();
        chk("en_issue", mem_valid, 1);
        enable = 0;
        tick(); tick(); tick();
        chk("en_ack", d_ack, 1);
        chk("en_rdata", d_rdata, 32'hDEADBEEF);
        d_addr = 32'h104;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("en_blocked_valid", mem_valid, 0);
            chk("en_blocked_busy", busy, 0);
        end
        enable = 1;
        tick();
        chk("en_resume_valid", mem_valid, 1);
        chk("en_resume_addr", mem_addr, 32'h104);
        for (int c = 0; c <= LAT; c++) tick();
        chk("en_resume_ack", d_ack, 1);
        chk("en_resume_rdata", d_rdata, 32'h0104600D);
        d_req = 0;
        tick();

        // Reset in WAIT aborts the transaction without an ack.
        i_req = 1; i_addr = 32'h204;
        tick(); tick();
        chk("pre_rst_busy", busy, 1);
        rst = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", mem_valid, 0);
        chk("arst_maddr", mem_addr, 0);
        chk("arst_irdata", i_rdata, 0);
        chk("arst_drdata", d_rdata, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("arst_noack", {i_ack, d_ack}, 0);
        end
        rst = 1;
        tick();
        chk("post_rst_valid", mem_valid, 1);
        chk("post_rst_addr", mem_addr, 32'h204);
        tick(); tick();
        chk("post_rst_noack", i_ack, 0);
        tick();
        chk("post_rst_ack", i_ack, 1);
        chk("post_rst_rdata", i_rdata, 32'h0BADF00D);
        i_req = 0;
        tick();

        // MEM_LAT=1 instance, back-to-back loads.
        d_req1 = 1; d_addr1 = 32'h40;
        tick();
        chk("l1_valid", mem_valid1, 1);
        chk("l1_addr", mem_addr1, 32'h40);
        tick();
        chk("l1_noack", d_ack1, 0);
        tick();
        chk("l1_ack", d_ack1, 1);
        chk("l1_rdata", d_rdata1, 32'hCAFEF00D);
        d_addr1 = 32'h44;
        tick();
        chk("l1_gap_valid", mem_valid1, 0);
        chk("l1_gap_busy", busy1, 0);
        tick();
        chk("l1_b2b_valid", mem_valid1, 1);
        chk("l1_b2b_addr", mem_addr1, 32'h44);
        tick(); tick();
        chk("l1_b2b_ack", d_ack1, 1);
        chk("l1_b2b_rdata", d_rdata1, 32'h5A5A0044);
        d_req1 = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
